// File: rtl/count_sched_if.sv
// count_sched_if: request/grant/counter bundle between requesters (master)
// and the count_sched time-slice scheduler (slave).
interface count_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3
);
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   len;
  logic [NREQ-1:0]         gnt;
  logic                    busy;
  logic [WIDTH-1:0]        count;
  logic                    done;
  logic [$clog2(NREQ)-1:0] done_id;

  modport master (
    output req, len,
    input  gnt, busy, count, done, done_id
  );

  modport slave (
    input  req, len,
    output gnt, busy, count, done, done_id
  );
endinterface

// File: rtl/count_sched.sv
// count_sched: shares one WIDTH-bit up-counter between NREQ requesters.
// A winner is chosen, its length is latched, the counter runs 0..Lw,
// then done pulses with the winner's index and arbitration restarts.
// Build option: COUNT_SCHED_FIXED_PRIO_EN selects fixed lowest-index
// priority instead of the default round-robin search.
//
// state | meaning
// IDLE  | waiting for any req; arbitrates on every edge
// RUN   | grant held, counter advancing toward the latched length
// DONE  | one-cycle completion pulse, always returns to IDLE
module count_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 3
) (
  input logic          clk,
  input logic          res,
  count_sched_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] lw, lw_nxt;
  logic [IW-1:0]    cur, cur_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;
  logic [IW-1:0]    win, idx;
  logic             found;
  logic [WIDTH-1:0] len_w;

  // Pick the winner: first requesting bit in search order.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef COUNT_SCHED_FIXED_PRIO_EN
      idx = IW'(k);
`else
      idx = IW'((int'(ptr) + 1 + k) % NREQ);
`endif
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Select the winner's length from the packed len bus.
  always_comb begin
    len_w = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) len_w = bus.len[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and datapath update; len is captured only at grant time.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lw_nxt    = lw;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          lw_nxt    = len_w;
          cur_nxt   = win;
          ptr_nxt   = win;
        end
      end
      RUN: begin
        if (cnt == lw) state_nxt = DONE;
        else           cnt_nxt   = cnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset leaves requester 0 at top priority.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      cnt   <= '0;
      lw    <= '0;
      cur   <= '0;
      ptr   <= IW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      lw    <= lw_nxt;
      cur   <= cur_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Outputs decoded from state so reset clears them without waiting for clk.
  always_comb begin
    bus.gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.gnt[i] = (state == RUN) && (cur == IW'(i));
    end
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.done_id = (state == DONE) ? cur : '0;
    bus.count   = cnt;
  end
endmodule

// File: tb/tb_count_sched.sv
// Scoreboard bench for count_sched (NREQ=4, WIDTH=3). Stimulus pushes the
// expected {id, length} of each interval; a negedge monitor follows every
// grant and pops/compares on each done pulse.
module tb_count_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 3;

  logic clk = 1'b0;
  logic res;

  count_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  count_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int ln;
  } exp_t;

  exp_t q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks each grant window and scores it when done appears.
  int         run_n = 0;
  logic [3:0] run_gnt = '0;
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] one;
    if (!res) begin
      run_n = 0;
    end else begin
      if (bus.gnt != 0) begin
        if (run_n == 0) run_gnt = bus.gnt;
        else check("gnt_stable", int'(bus.gnt), int'(run_gnt));
        check("count_seq", int'(bus.count), run_n);
        check("busy_run", int'(bus.busy), 1);
        run_n++;
      end
      if (bus.done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e   = q.pop_front();
          one = 4'b0001;
          check("done_id", int'(bus.done_id), e.id);
          check("gnt_onehot", int'(run_gnt), int'(one << e.id));
          check("gnt_cycles", run_n, e.ln + 1);
          check("busy_done", int'(bus.busy), 1);
          check("gnt_off_done", int'(bus.gnt), 0);
        end
        run_n = 0;
      end
    end
  end

  task automatic push(input int id, input int ln);
    exp_t e;
    e.id = id;
    e.ln = ln;
    q.push_back(e);
  endtask

  task automatic set_len(input int i, input int v);
    bus.len[i*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  // Apply req while idle and check the one-cycle grant latency.
  task automatic start(input string name, input logic [3:0] r, input int exp_gnt);
    bus.req = r;
    @(posedge clk); #1;
    check(name, int'(bus.gnt), exp_gnt);
    check({name, "_cnt0"}, int'(bus.count), 0);
    #1;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (!bus.done && cyc < 40);
    if (!bus.done) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int cyc;
    int n;
    int rr_ids[5];
    int fp_ids[3];

`ifdef COUNT_SCHED_FIXED_PRIO_EN
    rr_ids = '{0, 0, 0, 0, 0};
    fp_ids = '{1, 1, 1};
`else
    rr_ids = '{0, 1, 2, 3, 0};
    fp_ids = '{1, 3, 1};
`endif

    res     = 1'b0;
    bus.req = '0;
    bus.len = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", int'(bus.gnt), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_done_id", int'(bus.done_id), 0);
    @(negedge clk) res = 1'b1;
    idle(1);

    // Reset mid-run: abort at count=3, no done, regrant after release.
    set_len(0, 5);
    start("abort_gnt", 4'b0001, 1);
    n = 0;
    while (bus.count != 3 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("abort_reach3", int'(bus.count), 3);
    res = 1'b0;
    #1;
    check("abort_gnt_clr", int'(bus.gnt), 0);
    check("abort_cnt_clr", int'(bus.count), 0);
    check("abort_busy_clr", int'(bus.busy), 0);
    check("abort_no_done", int'(bus.done), 0);
    push(0, 5);
    repeat (2) @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
    check("rearb_gnt", int'(bus.gnt), 1);
    check("rearb_cnt", int'(bus.count), 0);
    wait_done("rearb", cyc);
    bus.req = '0;
    idle(2);

    // Single request, length 3.
    set_len(2, 3);
    push(2, 3);
    start("single_gnt", 4'b0100, 4);
    wait_done("single", cyc);
    bus.req = '0;
    idle(1);
    check("single_idle_busy", int'(bus.busy), 0);
    check("single_idle_done", int'(bus.done), 0);
    check("single_idle_cnt", int'(bus.count), 3);
    idle(1);

    // Zero length: one RUN cycle.
    set_len(0, 0);
    push(0, 0);
    start("zero_gnt", 4'b0001, 1);
    wait_done("zero", cyc);
    check("zero_period", cyc, 1);
    bus.req = '0;
    idle(2);

    // Max length with len changed mid-run.
    set_len(1, 7);
    push(1, 7);
    start("max_gnt", 4'b0010, 2);
    set_len(1, 2);
    wait_done("max", cyc);
    check("max_cnt_hold", int'(bus.count), 7);
    bus.req = '0;
    idle(2);

    // Round-robin from reset, all requesters, len=1.
    res = 1'b0;
    @(negedge clk) res = 1'b1;
    idle(1);
    bus.len = {3'd1, 3'd1, 3'd1, 3'd1};
    for (int k = 0; k < 5; k++) push(rr_ids[k], 1);
    start("rr_first_gnt", 4'b1111, 1);
    for (int k = 0; k < 5; k++) begin
      wait_done("rr", cyc);
      if (k > 0) check("rr_period", cyc, 4);
    end
    bus.req = '0;
    idle(2);

    // Requesters 1 and 3 held together.
    for (int k = 0; k < 3; k++) push(fp_ids[k], 1);
    start("pair_first_gnt", 4'b1010, 2);
    for (int k = 0; k < 3; k++) wait_done("pair", cyc);
    bus.req = '0;
    idle(3);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/count_sched.md
# count_sched

Time-slice scheduler that shares one WIDTH-bit synchronous up-counter between NREQ requesters. Each requester asks for an interval of a given length. The block arbitrates between them, grants one requester at a time, and runs the counter from 0 up to that requester's length. It then pulses done and re-arbitrates. It sits between the requesting blocks and the counter datapath and is the only agent that advances the counter.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 3, counter width; interval lengths use the same width
- clk  in  1  rising-edge clock
- res  in  1  reset; asynchronous, active-low
- req  in  NREQ  level request, one bit per requester
- len  in  NREQ*WIDTH  packed lengths; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, high for the whole RUN phase
- busy  out  1  high in RUN and DONE
- count  out  WIDTH  counter value
- done  out  1  one-cycle pulse at the end of an interval
- done_id  out  $clog2(NREQ)  index of the finished requester; valid while done=1

## Operation
- States: IDLE, RUN, DONE. Encoding is left to the implementation.
- Reset (res=0) takes effect immediately regardless of clk:
  - state=IDLE; gnt=0, busy=0, count=0, done=0, done_id=0
  - last-grant pointer=NREQ-1, so requester 0 has top round-robin priority after reset.
- IDLE, req==0: stay in IDLE; outputs hold at their reset values, except count, which holds its last value.
- IDLE, req!=0:
  - Pick the winner w as the first set bit searching upward from pointer+1, wrapping around.
  - Capture len[w] into an internal register Lw.
  - Next state RUN: gnt=1<<w, count=0, pointer=w.
- RUN: count increments by 1 each cycle.
  - When count==Lw: next state DONE, gnt=0, done=1, done_id=w, count holds at Lw.
  - Lw==0 gives a single RUN cycle.
  - The counter never wraps inside an interval, because Lw ≤ 2^WIDTH-1.
- DONE: lasts one cycle, then always returns to IDLE. done drops to 0 and busy drops to 0.
- len is sampled only at grant; changes during RUN are ignored.
- req changes during RUN/DONE are ignored (no abort). A requester still asserting req in the next IDLE is eligible again under normal arbitration.
- Simultaneous requests resolve only by the pointer; requester index is never a tie-breaker beyond the search order.

## Timing
- req is sampled at the edge where state=IDLE. gnt and count=0 are visible after that edge: 1-cycle latency.
- gnt is high for exactly Lw+1 cycles; count shows 0,1,…,Lw during those cycles.
- done is high for exactly 1 cycle, in the cycle immediately after the last RUN cycle.
- Back-to-back intervals: one IDLE cycle sits between DONE and the next RUN. Period per interval is Lw+3 cycles.
- res asserted mid-RUN: gnt, busy and count clear asynchronously. No done is issued for the aborted interval.
- res deasserted: the first arbitration happens on the first rising edge with res=1.

## Configuration
- COUNT_SCHED_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest-index requesting bit always wins. The pointer is still updated but not used.
  - Undefined (default): round-robin as described in Operation.
  - All other behaviour is identical in both builds.

## Test plan
- Reset mid-run, NREQ=4, WIDTH=3: req=4'b0001, len0=5. Assert res=0 while count=3 → gnt=0, count=0, busy=0 immediately. No done pulse. After release, requester 0 is granted again with count from 0.
- Single request: req=4'b0100, len2=3 → gnt=4'b0100 one cycle later. count runs 0,1,2,3. Then done=1 with done_id=2 for 1 cycle, then IDLE.
- Zero length: req=4'b0001, len0=0 → gnt high 1 cycle with count=0, then done=1, done_id=0.
- Round-robin: req=4'b1111 held, all len=1, from reset → grant order 0,1,2,3,0. Each gnt lasts 2 cycles; the period is 4 cycles.
- Fixed priority (COUNT_SCHED_FIXED_PRIO_EN defined): req=4'b1010 held → requester 1 is granted every time and requester 3 is never granted.
- Max length and len stability: len1=7, changed to 2 during RUN → count reaches 7 (no wrap, change ignored). done_id=1. gnt is high exactly 8 cycles.
